// File: rtl/secciones_pkg.sv
// Shared types and helpers for the section sequencer: section codes and their quadrant masks.
package secciones_pkg;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_Q1    = 3'd1,
    S_Q2    = 3'd2,
    S_Q3    = 3'd3,
    S_Q4    = 3'd4
  } seccion_t;

  localparam int unsigned NUM_SECCIONES = 5;
  localparam seccion_t    ULTIMA        = seccion_t'(3'(NUM_SECCIONES - 1));

  // Section k lights the low k quadrants.
  function automatic logic [3:0] mask_of(input seccion_t s);
    logic [3:0] m;
    m = 4'b0000;
    unique case (s)
      S_CLEAR: m = 4'b0000;
      S_Q1:    m = 4'b0001;
      S_Q2:    m = 4'b0011;
      S_Q3:    m = 4'b0111;
      S_Q4:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Button conditioning: 2-flop synchronizer, counting debouncer and a one-cycle rising-edge event.
module antirrebote #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic evento
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          estable_q, estable_d;
  logic          evento_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the sample disagrees with the accepted level.
  always_comb begin
    estable_d = estable_q;
    cnt_d     = '0;
    if (sync2_q != estable_q) begin
      if (cnt_q == CNT_MAX) begin
        estable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      estable_q <= 1'b0;
      cnt_q     <= '0;
      evento_q  <= 1'b0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      estable_q <= estable_d;
      cnt_q     <= cnt_d;
      evento_q  <= estable_d & ~estable_q;
    end
  end

  assign evento = evento_q;

endmodule

// File: rtl/secuenciador_secciones.sv
// Section sequencer: collects debounced next/clear requests and auto ticks, applies them on frame_start.
module secuenciador_secciones
  import secciones_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned AUTO_FRAMES     = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_clear,
  input  logic       auto_en,
  input  logic       frame_start,
  output logic [2:0] seccion_actual,
  output logic [3:0] quadrant_mask,
  output logic       update
);

  localparam int unsigned AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_FRAMES - 1);

  logic          ev_next, ev_clear;
  logic          pend_next_q, pend_next_d;
  logic          pend_clear_q, pend_clear_d;
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  seccion_t      estado_q, estado_d;
  logic [3:0]    mask_q, mask_d;
  logic          update_q, update_d;
  logic          auto_tick, transicion;

  antirrebote #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rebote_next (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_next),
    .evento(ev_next)
  );

  antirrebote #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rebote_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .evento(ev_clear)
  );

  always_comb begin
    auto_tick  = frame_start & auto_en & (auto_cnt_q == AUTO_MAX);
    transicion = frame_start & (pend_clear_q | pend_next_q | auto_tick);

    estado_d = estado_q;
    if (frame_start) begin
      if (pend_clear_q) begin
        estado_d = S_CLEAR;
      end else if (pend_next_q | auto_tick) begin
        estado_d = (estado_q >= ULTIMA) ? S_CLEAR : seccion_t'(estado_q + 3'd1);
      end
    end

    // An event coinciding with frame_start survives into the next frame.
    pend_next_d  = frame_start ? ev_next  : (pend_next_q  | ev_next);
    pend_clear_d = frame_start ? ev_clear : (pend_clear_q | ev_clear);

    auto_cnt_d = auto_cnt_q;
    if (!auto_en || transicion) begin
      auto_cnt_d = '0;
    end else if (frame_start) begin
      auto_cnt_d = auto_cnt_q + AW'(1);
    end

    mask_d   = mask_of(estado_d);
    update_d = (estado_d != estado_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q     <= S_CLEAR;
      mask_q       <= 4'b0000;
      update_q     <= 1'b0;
      pend_next_q  <= 1'b0;
      pend_clear_q <= 1'b0;
      auto_cnt_q   <= '0;
    end else begin
      estado_q     <= estado_d;
      mask_q       <= mask_d;
      update_q     <= update_d;
      pend_next_q  <= pend_next_d;
      pend_clear_q <= pend_clear_d;
      auto_cnt_q   <= auto_cnt_d;
    end
  end

  assign seccion_actual = estado_q;
  assign quadrant_mask  = mask_q;
  assign update         = update_q;

endmodule

// File: tb/tb_secuenciador_secciones.sv
// Directed bench for secuenciador_secciones with DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, 50-cycle frames.
module tb_secuenciador_secciones;

  localparam int unsigned DEB     = 4;
  localparam int unsigned AUTO    = 3;
  localparam int          PERIODO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_clear = 1'b0;
  logic       auto_en = 1'b0;
  logic       frame_start = 1'b0;
  logic [2:0] seccion_actual;
  logic [3:0] quadrant_mask;
  logic       update;

  int vectors = 0;
  int errs    = 0;
  int fcnt    = 0;
  int upd_cnt = 0;
  bit fs_en   = 1'b1;
  bit fs_done = 1'b0;

  always #5 clk = ~clk;

  secuenciador_secciones #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_FRAMES    (AUTO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_next      (btn_next),
    .btn_clear     (btn_clear),
    .auto_en       (auto_en),
    .frame_start   (frame_start),
    .seccion_actual(seccion_actual),
    .quadrant_mask (quadrant_mask),
    .update        (update)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: outputs sampled 1 time unit after the edge, then next inputs set up.
  task automatic cyc();
    @(posedge clk);
    #1;
    fs_done = frame_start;
    if (update === 1'b1) upd_cnt++;
    fcnt++;
    frame_start = fs_en && (fcnt % PERIODO == PERIODO - 1);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // Returns one cycle after a frame_start has been clocked in.
  task automatic wait_frame(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2 * PERIODO && !got; i++) begin
      cyc();
      got = fs_done;
    end
    chk(tag, 8'(got), 8'd1);
  endtask

  task automatic press(input bit clr);
    if (clr) btn_clear = 1'b1;
    else     btn_next  = 1'b1;
    run(8);
    btn_clear = 1'b0;
    btn_next  = 1'b0;
    run(8);
  endtask

  initial begin
    // Reset and idle
    run(3);
    reset = 1'b0;
    chk("rst_sec", 8'(seccion_actual), 8'd0);
    chk("rst_mask", 8'(quadrant_mask), 8'h0);
    chk("rst_upd", 8'(update), 8'd0);
    upd_cnt = 0;
    run(200);
    chk("idle_sec", 8'(seccion_actual), 8'd0);
    chk("idle_upd_cnt", 8'(upd_cnt), 8'd0);

    // Single clean press
    wait_frame("wf_align");
    upd_cnt = 0;
    btn_next = 1'b1;
    run(20);
    btn_next = 1'b0;
    wait_frame("wf_next");
    chk("next_sec", 8'(seccion_actual), 8'd1);
    chk("next_mask", 8'(quadrant_mask), 8'h1);
    chk("next_upd", 8'(update), 8'd1);
    wait_frame("wf_next_hold");
    chk("next_hold_sec", 8'(seccion_actual), 8'd1);
    chk("next_upd_cnt", 8'(upd_cnt), 8'd1);

    // Bouncing press
    upd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      btn_next = (i % 2 == 0);
      run(2);
    end
    btn_next = 1'b1;
    run(20);
    btn_next = 1'b0;
    run(10);
    wait_frame("wf_bounce");
    chk("bounce_sec", 8'(seccion_actual), 8'd2);
    chk("bounce_mask", 8'(quadrant_mask), 8'h3);

    // Five presses collapse into one advance
    fs_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_next = 1'b1;
      run(6);
      btn_next = 1'b0;
      run(6);
    end
    fs_en = 1'b1;
    wait_frame("wf_five");
    chk("five_sec", 8'(seccion_actual), 8'd3);
    chk("five_mask", 8'(quadrant_mask), 8'h7);
    wait_frame("wf_five_hold");
    chk("five_hold_sec", 8'(seccion_actual), 8'd3);
    chk("five_upd_cnt", 8'(upd_cnt), 8'd2);

    // Wrap 3 -> 4 -> 0
    press(1'b0);
    wait_frame("wf_q4");
    chk("q4_sec", 8'(seccion_actual), 8'd4);
    chk("q4_mask", 8'(quadrant_mask), 8'hF);
    press(1'b0);
    wait_frame("wf_wrap");
    chk("wrap_sec", 8'(seccion_actual), 8'd0);
    chk("wrap_mask", 8'(quadrant_mask), 8'h0);
    chk("wrap_upd", 8'(update), 8'd1);

    // Next and clear in the same frame: clear wins
    repeat (3) begin
      press(1'b0);
      wait_frame("wf_to3");
    end
    chk("to3_sec", 8'(seccion_actual), 8'd3);
    press(1'b0);
    press(1'b1);
    wait_frame("wf_nc");
    chk("next_clear_sec", 8'(seccion_actual), 8'd0);
    chk("next_clear_upd", 8'(update), 8'd1);
    press(1'b1);
    wait_frame("wf_clr0");
    chk("clear_in0_sec", 8'(seccion_actual), 8'd0);
    chk("clear_in0_upd", 8'(update), 8'd0);

    // Auto advance every 3 frames
    auto_en = 1'b1;
    wait_frame("wf_a1");
    wait_frame("wf_a2");
    chk("auto2_sec", 8'(seccion_actual), 8'd0);
    wait_frame("wf_a3");
    chk("auto3_sec", 8'(seccion_actual), 8'd1);
    chk("auto3_upd", 8'(update), 8'd1);
    wait_frame("wf_a4");
    wait_frame("wf_a5");
    chk("auto5_sec", 8'(seccion_actual), 8'd1);
    wait_frame("wf_a6");
    chk("auto6_sec", 8'(seccion_actual), 8'd2);
    wait_frame("wf_a7");
    press(1'b1);
    wait_frame("wf_a8");
    chk("auto_clear_sec", 8'(seccion_actual), 8'd0);
    wait_frame("wf_a9");
    wait_frame("wf_a10");
    chk("auto_restart_hold", 8'(seccion_actual), 8'd0);
    wait_frame("wf_a11");
    chk("auto_restart_adv", 8'(seccion_actual), 8'd1);

    // Clear coinciding with auto_tick
    wait_frame("wf_a12");
    wait_frame("wf_a13");
    chk("pre_tick_sec", 8'(seccion_actual), 8'd1);
    press(1'b1);
    wait_frame("wf_a14");
    chk("clear_tick_sec", 8'(seccion_actual), 8'd0);
    wait_frame("wf_a15");
    wait_frame("wf_a16");
    chk("clear_tick_hold", 8'(seccion_actual), 8'd0);
    wait_frame("wf_a17");
    chk("clear_tick_restart", 8'(seccion_actual), 8'd1);
    auto_en = 1'b0;
    press(1'b1);
    wait_frame("wf_back0");
    chk("back0_sec", 8'(seccion_actual), 8'd0);

    // Event lands on the frame_start edge itself (2+4+1 edges after the press)
    for (int i = 0; i < 2 * PERIODO && (PERIODO - fcnt % PERIODO) != 7; i++) cyc();
    btn_next = 1'b1;
    upd_cnt = 0;
    wait_frame("wf_same");
    chk("same_cycle_sec", 8'(seccion_actual), 8'd0);
    chk("same_cycle_upd", 8'(update), 8'd0);
    run(3);
    btn_next = 1'b0;
    wait_frame("wf_same_next");
    chk("same_cycle_adv", 8'(seccion_actual), 8'd1);
    chk("same_cycle_cnt", 8'(upd_cnt), 8'd1);

    // Reset with a request pending drops it
    press(1'b0);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    chk("rst_mid_sec", 8'(seccion_actual), 8'd0);
    chk("rst_mid_mask", 8'(quadrant_mask), 8'h0);
    chk("rst_mid_upd", 8'(update), 8'd0);
    upd_cnt = 0;
    wait_frame("wf_rst_drop");
    chk("rst_drop_sec", 8'(seccion_actual), 8'd0);
    chk("rst_drop_cnt", 8'(upd_cnt), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/secuenciador_secciones.md
# secuenciador_secciones

Controller that sequences the quadrant painter by generating its 3-bit section code. Debounces two push-buttons (next, clear) and optionally auto-advances every N frames. Applies every section change only on a frame boundary, so the painter never switches quadrant colours mid-frame. Sits between the board buttons / VGA sync generator and the painter's `seccion_actual` input.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable samples required to accept a button level (10 ms at 25 MHz); legal ≥ 1.
- `AUTO_FRAMES`, default 60: frames per automatic advance; legal ≥ 1.
- `clk`  in  1  pixel clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `btn_next`  in  1  raw asynchronous button, active-high; request advance to the next section.
- `btn_clear`  in  1  raw asynchronous button, active-high; request return to section 0.
- `auto_en`  in  1  level; enables automatic advance (synchronous to clk).
- `frame_start`  in  1  one-cycle pulse from the sync generator at start of vertical blanking.
- `seccion_actual`  out  3  current section code, 0..4; drives the painter.
- `quadrant_mask`  out  4  quadrants lit in the current section; bit k = quadrant k+1.
- `update`  out  1  one-cycle pulse marking the cycle `seccion_actual` takes a new value.

## Operation
- Input path per button: 2-flop synchronizer, then debouncer.
  - Debouncer holds a stable level (reset 0) and a counter.
  - Counter increments while the synchronized sample differs from the stable level; it clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES−1 with the sample still differing, the stable level flips and the counter clears.
  - A rising edge of the stable level produces a one-cycle event.
- Pending flags `pend_next` and `pend_clear` are set by their events.
  - Multiple next events before one frame_start collapse into a single advance.
  - An event in the same cycle as frame_start is not consumed by that frame_start; it stays pending for the next one.
- FSM states, encoded as the section value: S_CLEAR=0, S_Q1=1, S_Q2=2, S_Q3=3, S_Q4=4. Reset state is S_CLEAR.
- Auto counter:
  - Increments on each frame_start while auto_en=1.
  - `auto_tick` is asserted when frame_start arrives with the counter = AUTO_FRAMES−1.
  - Clears when auto_en=0, on auto_tick, and on any applied transition.
- Transition on frame_start only, in priority order:
  - `pend_clear` → S_CLEAR.
  - else `pend_next` or `auto_tick` → next state: Q1→Q2→Q3→Q4, Q4 wraps to S_CLEAR, and S_CLEAR→Q1.
  - else hold.
  - Both pending flags clear on every frame_start, excluding events arriving that same cycle.
- `quadrant_mask` for section k has its low k bits set: 0→0000, 1→0001, 2→0011, 3→0111, 4→1111.
- `update` is asserted only if the new section differs from the old one; clear while already in S_CLEAR gives no update.

## Timing
- All outputs are registered.
- Reset values: `seccion_actual`=0, `quadrant_mask`=0000, `update`=0. Synchronizers, debounce stable levels, counters and pending flags are all 0.
- `frame_start` at cycle t → new `seccion_actual`, `quadrant_mask` and `update` at t+1. `seccion_actual` is constant between frame_starts.
- Button press to pending flag: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge cycle. Visible at the first frame_start strictly after the flag sets, plus 1 cycle.
- A button release is debounced identically but generates no event.
- A clear event and auto_tick on the same frame_start resolve to S_CLEAR; the auto counter restarts.
- AUTO_FRAMES=1 with auto_en=1 advances on every frame_start.
- Reset asserted mid-debounce or mid-sequence returns everything to reset values on the next edge. Any pending request is dropped.

## Structure
- Package `secciones_pkg`:
  - `typedef enum logic [2:0] seccion_t` {S_CLEAR, S_Q1, S_Q2, S_Q3, S_Q4}.
  - `NUM_SECCIONES` = 5.
  - Function `mask_of(seccion_t)` returning the 4-bit mask.
- Sub-module `antirrebote`: synchronizer, debouncer and rising-edge event, parameterized by DEBOUNCE_CYCLES. Instantiated twice.
- Counter widths are `$clog2` of the parameter, minimum 1 bit.

## Test plan
Simulation parameters: DEBOUNCE_CYCLES=4, AUTO_FRAMES=3; frame_start pulses every 50 cycles.
- Reset: hold reset 3 cycles, release → `seccion_actual`=0, `quadrant_mask`=0000, `update`=0; no change over 200 cycles.
- Next press: btn_next high for 20 cycles → event after 2+4+1 cycles. At the following frame_start+1: `seccion_actual`=1, mask 0001, `update` pulses exactly once.
- Bounce: btn_next toggles every 2 cycles for 12 cycles, then settles high → exactly one advance. Five clean presses within one frame → exactly one advance.
- Wrap and clear: advance to 4 (mask 1111), then one more next → 0 (mask 0000). From 3, press next and clear in the same frame → 0.
- Auto mode: auto_en=1 from section 0 → section 1 at the 3rd frame_start, 2 at the 6th. A clear press between them → 0 at the next frame, and the auto counter restarts.
- Same-cycle event: debounced next event coincident with frame_start → no change at t+1; advance occurs at the following frame_start+1. Reset asserted while pend_next=1 → no advance afterward.
